mem_stage: RTL and testbench

- MEM pipeline stage directly downstream of the EX/MEM latch. It consumes the latched ALU result, store data, destination register, control bits and opcode.
- Performs byte, halfword and word loads/stores against an external variable-latency data memory over a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Registers the WB-bound fields, so the block also acts as the MEM/WB latch.

---
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Request/acknowledge bus between the MEM stage and the external data memory.
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [31:0]           dmem_wdata;
  logic                  dmem_ack;
  logic [31:0]           dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: sub-word loads/stores over a req/ack data-memory bus,
// pipeline stall while an access is outstanding, and the MEM/WB latch.
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [DATA_WIDTH-1:0] read_data_2_in,
  input  logic [4:0]            write_register_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  is_halt_in,
  input  logic [5:0]            opcode_in,
  mem_stage_if.master           dmem_bus,
  output logic                  stall_out,
  output logic [DATA_WIDTH-1:0] read_data_out,
  output logic [DATA_WIDTH-1:0] alu_result_out,
  output logic [4:0]            write_register_out,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic                  is_halt_out,
  output logic                  misalign_err,
  output logic                  bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;

  function automatic size_e access_size(input logic [5:0] op, input logic is_store);
    size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (op)
        OP_SB:   sz = SZ_BYTE;
        OP_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (op)
        OP_LB, OP_LBU: sz = SZ_BYTE;
        OP_LH, OP_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input size_e sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_q, req_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_out_q, rdata_out_d, alu_out_q, alu_out_d;
  logic [4:0]              wreg_q, wreg_d;
  logic                    regw_q, regw_d, m2r_q, m2r_d, halt_q, halt_d;
  logic                    mis_q, mis_d, bus_q, bus_d;
  logic [DATA_WIDTH-1:0]   hold_alu_q, hold_alu_d;
  logic [4:0]              hold_wreg_q, hold_wreg_d;
  logic                    hold_regw_q, hold_regw_d, hold_m2r_q, hold_m2r_d;
  logic                    hold_halt_q, hold_halt_d, hold_store_q, hold_store_d;
  logic                    hold_sgn_q, hold_sgn_d;
  size_e                   hold_size_q, hold_size_d;

  logic                    is_store_s, is_mem_s, sgn_s, misaligned_s;
  logic [1:0]              lane_s;
  size_e                   size_s;
  logic [3:0]              be_s, be_store_s;
  logic [DATA_WIDTH-1:0]   wdata_s;

  // A set write bit wins over a set read bit: such an op is a store.
  assign is_store_s = mem_write_in;
  assign is_mem_s   = mem_read_in | mem_write_in;
  assign sgn_s      = (opcode_in == OP_LB) || (opcode_in == OP_LH);
  assign lane_s     = alu_result_in[1:0];

  // Access size, alignment, byte enables and lane-replicated store data.
  always_comb begin
    size_s       = access_size(opcode_in, is_store_s);
    misaligned_s = 1'b0;
    wdata_s      = read_data_2_in;
    be_store_s   = 4'b1111;
    case (size_s)
      SZ_BYTE: begin
        misaligned_s = 1'b0;
        wdata_s      = {4{read_data_2_in[7:0]}};
        be_store_s   = 4'b0001 << lane_s;
      end
      SZ_HALF: begin
        misaligned_s = lane_s[0];
        wdata_s      = {2{read_data_2_in[15:0]}};
        be_store_s   = lane_s[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misaligned_s = (lane_s != 2'b00);
        wdata_s      = read_data_2_in;
        be_store_s   = 4'b1111;
      end
    endcase
    be_s = is_store_s ? be_store_s : 4'b1111;
  end

  // IDLE/WAIT next-state, bus, writeback and stall logic; WB defaults to a bubble.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    hold_alu_d   = hold_alu_q;
    hold_wreg_d  = hold_wreg_q;
    hold_regw_d  = hold_regw_q;
    hold_m2r_d   = hold_m2r_q;
    hold_halt_d  = hold_halt_q;
    hold_store_d = hold_store_q;
    hold_sgn_d   = hold_sgn_q;
    hold_size_d  = hold_size_q;
    rdata_out_d  = '0;
    alu_out_d    = '0;
    wreg_d       = 5'd0;
    regw_d       = 1'b0;
    m2r_d        = 1'b0;
    halt_d       = 1'b0;
    mis_d        = 1'b0;
    bus_d        = 1'b0;
    stall_out    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem_s && misaligned_s) begin
          mis_d = 1'b1;
          req_d = 1'b0;
          we_d  = 1'b0;
        end else if (is_mem_s) begin
          stall_out    = 1'b1;
          req_d        = 1'b1;
          we_d         = is_store_s;
          addr_d       = alu_result_in[ADDR_WIDTH+1:2];
          be_d         = be_s;
          wdata_d      = wdata_s;
          hold_alu_d   = alu_result_in;
          hold_wreg_d  = write_register_in;
          hold_regw_d  = reg_write_in & ~is_store_s;
          hold_m2r_d   = mem_to_reg_in;
          hold_halt_d  = is_halt_in;
          hold_store_d = is_store_s;
          hold_sgn_d   = sgn_s;
          hold_size_d  = size_s;
          cnt_d        = '0;
          state_d      = S_WAIT;
        end else begin
          req_d     = 1'b0;
          we_d      = 1'b0;
          alu_out_d = alu_result_in;
          wreg_d    = write_register_in;
          regw_d    = reg_write_in;
          m2r_d     = mem_to_reg_in;
          halt_d    = is_halt_in;
        end
      end
      S_WAIT: begin
        if (dmem_bus.dmem_ack) begin
          rdata_out_d = hold_store_q ? '0 :
                        extend_load(dmem_bus.dmem_rdata, hold_alu_q[1:0], hold_size_q, hold_sgn_q);
          alu_out_d   = hold_alu_q;
          wreg_d      = hold_wreg_q;
          regw_d      = hold_regw_q;
          m2r_d       = hold_m2r_q;
          halt_d      = hold_halt_q;
          req_d       = 1'b0;
          we_d        = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          bus_d   = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, bus, held EX/MEM fields and MEM/WB registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      rdata_out_q  <= '0;
      alu_out_q    <= '0;
      wreg_q       <= 5'd0;
      regw_q       <= 1'b0;
      m2r_q        <= 1'b0;
      halt_q       <= 1'b0;
      mis_q        <= 1'b0;
      bus_q        <= 1'b0;
      hold_alu_q   <= '0;
      hold_wreg_q  <= 5'd0;
      hold_regw_q  <= 1'b0;
      hold_m2r_q   <= 1'b0;
      hold_halt_q  <= 1'b0;
      hold_store_q <= 1'b0;
      hold_sgn_q   <= 1'b0;
      hold_size_q  <= SZ_BYTE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rdata_out_q  <= rdata_out_d;
      alu_out_q    <= alu_out_d;
      wreg_q       <= wreg_d;
      regw_q       <= regw_d;
      m2r_q        <= m2r_d;
      halt_q       <= halt_d;
      mis_q        <= mis_d;
      bus_q        <= bus_d;
      hold_alu_q   <= hold_alu_d;
      hold_wreg_q  <= hold_wreg_d;
      hold_regw_q  <= hold_regw_d;
      hold_m2r_q   <= hold_m2r_d;
      hold_halt_q  <= hold_halt_d;
      hold_store_q <= hold_store_d;
      hold_sgn_q   <= hold_sgn_d;
      hold_size_q  <= hold_size_d;
    end
  end

  assign dmem_bus.dmem_req   = req_q;
  assign dmem_bus.dmem_we    = we_q;
  assign dmem_bus.dmem_addr  = addr_q;
  assign dmem_bus.dmem_be    = be_q;
  assign dmem_bus.dmem_wdata = wdata_q;

  assign read_data_out      = rdata_out_q;
  assign alu_result_out     = alu_out_q;
  assign write_register_out = wreg_q;
  assign reg_write_out      = regw_q;
  assign mem_to_reg_out     = m2r_q;
  assign is_halt_out        = halt_q;
  assign misalign_err       = mis_q;
  assign bus_err            = bus_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops
// checked every cycle against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, read_data_2_in;
  logic [4:0]  write_register_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, is_halt_in;
  logic [5:0]  opcode_in;
  logic        stall_out, reg_write_out, mem_to_reg_out, is_halt_out, misalign_err, bus_err;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  write_register_out;

  mem_stage_if #(.ADDR_WIDTH(10)) dmem_bus ();

  mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .read_data_2_in(read_data_2_in),
    .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .is_halt_in(is_halt_in), .opcode_in(opcode_in),
    .dmem_bus(dmem_bus), .stall_out(stall_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_register_out(write_register_out), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out), .is_halt_out(is_halt_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Expected values for the current cycle; e_mode 0 = WB unchecked, 1 = bubble, 2 = full.
  logic        chk_en, exp_stall, e_req, e_we, e_regw, e_m2r, e_halt, e_mis, e_bus, e_rd_chk;
  logic [9:0]  e_addr;
  logic [3:0]  e_be;
  logic [31:0] e_wdata, e_alu, e_rd;
  logic [4:0]  e_wreg;
  int          e_mode;
  logic        last_we;
  logic [9:0]  last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic [5:0]  op_tab [0:9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [5:0] op, input bit st);
    if (st) return (op == 6'h28) ? 1 : (op == 6'h29) ? 2 : 4;
    return (op == 6'h20 || op == 6'h24) ? 1 : (op == 6'h21 || op == 6'h25) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [31:0] addr,
                                             input int sz, input bit sgn);
    logic [63:0] mask;
    logic [31:0] v;
    if (sz == 4) return word;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v = (word >> (8 * (addr % 4))) & mask[31:0];
    if (sgn && (v > (mask[31:0] >> 1))) v = v | ~mask[31:0];
    return v;
  endfunction

  task automatic set_wb_full(input logic [31:0] alu, input logic [4:0] wr, input logic rw,
                             input logic m2r, input logic halt, input logic [31:0] rd, input logic rd_chk);
    e_mode = 2; e_alu = alu; e_wreg = wr; e_regw = rw; e_m2r = m2r; e_halt = halt;
    e_rd = rd; e_rd_chk = rd_chk;
  endtask

  task automatic set_bubble();
    e_mode = 1; e_regw = 1'b0; e_halt = 1'b0;
  endtask

  // Presents one op at post-edge time and returns just after the edge that retires it.
  // delay = WAIT cycles before ack (>= 16 means the memory never answers).
  task automatic do_op(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic halt, input logic [5:0] op, input int delay, input logic [31:0] rdata);
    int  sz;
    bit  st, mem, mis, sgn;
    logic [31:0] lane;
    st   = mw;
    mem  = mr | mw;
    sz   = size_of(op, st);
    mis  = mem && ((alu & 32'(sz - 1)) != 32'd0);
    sgn  = !st && (op == 6'h20 || op == 6'h21);
    lane = alu % 4;
    alu_result_in = alu; read_data_2_in = rt; write_register_in = wr; reg_write_in = rw;
    mem_read_in = mr; mem_write_in = mw; mem_to_reg_in = m2r; is_halt_in = halt; opcode_in = op;
    dmem_bus.dmem_ack   = 1'($urandom_range(0, 1));
    dmem_bus.dmem_rdata = $urandom;
    exp_stall = mem && !mis;
    @(posedge clk); #1;
    dmem_bus.dmem_ack = 1'b0;
    e_mis = mis; e_bus = 1'b0;
    if (!mem || mis) begin
      e_req = 1'b0;
      if (mis) set_bubble();
      else set_wb_full(alu, wr, rw, m2r, halt, 32'd0, 1'b1);
      return;
    end
    e_req   = 1'b1;
    e_we    = st;
    e_addr  = 10'((alu >> 2) & 32'h3FF);
    e_be    = st ? 4'(((1 << sz) - 1) << lane) : 4'hF;
    e_wdata = (sz == 1) ? (rt & 32'hFF) * 32'h01010101 :
              (sz == 2) ? (rt & 32'hFFFF) * 32'h00010001 : rt;
    set_bubble();
    for (int k = 0; k < 16; k++) begin
      alu_result_in = $urandom; read_data_2_in = $urandom; write_register_in = 5'($urandom);
      reg_write_in = 1'($urandom); mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
      mem_to_reg_in = 1'($urandom); is_halt_in = 1'($urandom); opcode_in = 6'($urandom);
      dmem_bus.dmem_ack   = (k == delay);
      dmem_bus.dmem_rdata = (k == delay) ? rdata : $urandom;
      exp_stall = (k != delay) && (k != 15);
      @(posedge clk); #1;
      dmem_bus.dmem_ack = 1'b0;
      e_mis = 1'b0;
      if (k == delay) begin
        e_req = 1'b0;
        set_wb_full(alu, wr, rw && !st, m2r, halt, st ? 32'd0 : load_value(rdata, alu, sz, sgn), !st);
        break;
      end else if (k == 15) begin
        e_req = 1'b0; e_bus = 1'b1;
        set_bubble();
      end
    end
  endtask

  // Per-cycle comparison of the DUT against the model's current expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (dmem_bus.dmem_req === 1'b1) begin
        last_we = dmem_bus.dmem_we; last_addr = dmem_bus.dmem_addr;
        last_be = dmem_bus.dmem_be; last_wdata = dmem_bus.dmem_wdata;
      end
      if (chk_en) begin
        chk("stall_out", 32'(stall_out), 32'(exp_stall));
        chk("dmem_req", 32'(dmem_bus.dmem_req), 32'(e_req));
        if (e_req) begin
          chk("dmem_we", 32'(dmem_bus.dmem_we), 32'(e_we));
          chk("dmem_addr", 32'(dmem_bus.dmem_addr), 32'(e_addr));
          chk("dmem_be", 32'(dmem_bus.dmem_be), 32'(e_be));
          chk("dmem_wdata", dmem_bus.dmem_wdata, e_wdata);
        end
        chk("misalign_err", 32'(misalign_err), 32'(e_mis));
        chk("bus_err", 32'(bus_err), 32'(e_bus));
        if (e_mode != 0) begin
          chk("reg_write_out", 32'(reg_write_out), 32'(e_regw));
          chk("is_halt_out", 32'(is_halt_out), 32'(e_halt));
        end
        if (e_mode == 2) begin
          chk("alu_result_out", alu_result_out, e_alu);
          chk("write_register_out", 32'(write_register_out), 32'(e_wreg));
          chk("mem_to_reg_out", 32'(mem_to_reg_out), 32'(e_m2r));
          if (e_rd_chk) chk("read_data_out", read_data_out, e_rd);
        end
      end
    end
  end

  task automatic expect_idle_zero();
    e_req = 1'b0; e_mis = 1'b0; e_bus = 1'b0; exp_stall = 1'b0;
    set_wb_full(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(dmem_bus.dmem_req), 32'd0);
    chk({tag, "_we"}, 32'(dmem_bus.dmem_we), 32'd0);
    chk({tag, "_addr"}, 32'(dmem_bus.dmem_addr), 32'd0);
    chk({tag, "_be"}, 32'(dmem_bus.dmem_be), 32'd0);
    chk({tag, "_wdata"}, dmem_bus.dmem_wdata, 32'd0);
    chk({tag, "_rdata_out"}, read_data_out, 32'd0);
    chk({tag, "_alu_out"}, alu_result_out, 32'd0);
    chk({tag, "_wb_ctl"}, 32'({write_register_out, reg_write_out, mem_to_reg_out, is_halt_out}), 32'd0);
    chk({tag, "_errs"}, 32'({misalign_err, bus_err}), 32'd0);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
  endtask

  task automatic drive_nop();
    alu_result_in = 32'd0; read_data_2_in = 32'd0; write_register_in = 5'd0; reg_write_in = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0; is_halt_in = 1'b0; opcode_in = 6'd0;
  endtask

  initial begin
    int r, kind, dly;
    logic mr, mw;
    op_tab = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h3F};
    chk_en = 1'b0; reset = 1'b0; e_mode = 0;
    drive_nop();
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'd0;
    expect_idle_zero();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // Non-memory op: one-cycle latency, no stall.
    do_op(32'h00001234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 0, 32'd0);
    chk("nop_alu", alu_result_out, 32'h00001234);
    chk("nop_wreg", 32'(write_register_out), 32'd5);
    chk("nop_regw", 32'(reg_write_out), 32'd1);

    do_op(32'h00000103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h20, 0, 32'h80FF7F01);
    chk("lb_data", read_data_out, 32'hFFFFFF80);
    chk("lb_addr", 32'(last_addr), 32'h040);
    chk("lb_be", 32'(last_be), 32'hF);
    do_op(32'h00000103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h24, 0, 32'h80FF7F01);
    chk("lbu_data", read_data_out, 32'h00000080);

    do_op(32'h00000202, 32'h0000ABCD, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h29, 1, 32'd0);
    chk("sh_we", 32'(last_we), 32'd1);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_regw", 32'(reg_write_out), 32'd0);

    do_op(32'h00000006, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h23, 0, 32'd0);
    chk("lw_mis_err", 32'(misalign_err), 32'd1);
    chk("lw_mis_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("lw_mis_regw", 32'(reg_write_out), 32'd0);

    do_op(32'h00000010, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h23, 3, 32'hDEADBEEF);
    chk("lw_slow_data", read_data_out, 32'hDEADBEEF);

    do_op(32'h00000020, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h23, 99, 32'd0);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    chk("timeout_req", 32'(dmem_bus.dmem_req), 32'd0);
    do_op(32'h00005555, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 0, 32'd0);
    chk("after_timeout_alu", alu_result_out, 32'h00005555);
    chk("after_timeout_halt", 32'(is_halt_out), 32'd1);

    // Asynchronous reset in the middle of an access, then a stray ack.
    chk_en = 1'b0;
    drive_nop();
    alu_result_in = 32'h00000040; mem_read_in = 1'b1; opcode_in = 6'h23; reg_write_in = 1'b1;
    @(posedge clk); #1;
    chk("rst_pre_req", 32'(dmem_bus.dmem_req), 32'd1);
    @(posedge clk); #1;
    drive_nop();
    #2 reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dmem_bus.dmem_ack = 1'b0;
    chk("late_ack_regw", 32'(reg_write_out), 32'd0);
    chk("late_ack_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("late_ack_rdata", read_data_out, 32'd0);
    expect_idle_zero();
    chk_en = 1'b1;

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 6);
      mr = (kind == 1 || kind == 2 || kind == 5);
      mw = (kind == 3 || kind == 4 || kind == 5);
      r = $urandom_range(0, 19);
      dly = (r < 12) ? r % 4 : (r < 18) ? r : 99;
      do_op($urandom, $urandom, 5'($urandom), 1'($urandom), mr, mw, 1'($urandom),
            1'($urandom), op_tab[$urandom_range(0, 9)], dly, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
